// File: rtl/addsub_serial_ctrl.sv
// addsub_serial_ctrl
// Nibble-serial wide add/subtract controller. One 4-bit add/sub slice is
// stepped NIBBLES times, least-significant nibble first. The carry (or the
// inverted borrow) is chained between steps through a register. The
// controller sits between a valid/ready operand request port and a
// valid/ready result port, and it reports carry, signed-overflow and zero
// flags for the full W-bit operation.
//
// Optional build macro:
//   ADDSUB_SAT_EN - on signed overflow the result is replaced by the signed
//                   saturation limit. Leave it undefined for plain modulo
//                   2^W wrap.
module addsub_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One 4-bit slice step: a + (b ^ {4{sub}}) + cin.
  // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] slice_addsub(
    input logic [3:0] a_nib,
    input logic [3:0] b_nib,
    input logic       sub,
    input logic       cin
  );
    logic [3:0] bx;
    logic [3:0] low;
    logic [4:0] full;
    bx   = b_nib ^ {4{sub}};
    low  = {1'b0, a_nib[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    full = {1'b0, a_nib} + {1'b0, bx} + {4'b0000, cin};
    return {full[4], low[3], full[3:0]};
  endfunction

`ifdef ADDSUB_SAT_EN
  // Signed saturation limit, selected by the sign of operand A. On overflow
  // both operands of the effective addition share A's sign.
  function automatic logic [W-1:0] sat_value(input logic a_sign);
    logic [W-1:0] v;
    if (a_sign) begin
      v = {1'b1, {(W-1){1'b0}}};
    end else begin
      v = {1'b0, {(W-1){1'b1}}};
    end
    return v;
  endfunction
`endif

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          mode_r;
  logic          carry_r;
  logic [W-1:0]  result_r;
  logic          cout_r;
  logic          ovf_r;
  logic          zero_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic          accept_s;
  logic          last_s;
  logic [3:0]    a_nib_s;
  logic [3:0]    b_nib_s;
  logic [5:0]    slice_s;
  logic          slice_cout_s;
  logic          slice_c3_s;
  logic          ovf_step_s;
  logic [W-1:0]  res_step_s;
  logic [W-1:0]  res_final_s;
  logic          zero_final_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign busy      = busy_r;

  // Handshake qualifiers and the active nibble of the latched operands.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == ST_IDLE) && in_valid && in_ready_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    last_s  = (cnt_r == LAST_NIB);
    a_nib_s = a_r[{cnt_r, 2'b00} +: 4];
    b_nib_s = b_r[{cnt_r, 2'b00} +: 4];
  end

  // Slice evaluation and the merged (and optionally saturated) result.
  always_comb begin
    slice_s      = slice_addsub(a_nib_s, b_nib_s, mode_r, carry_r);
    slice_cout_s = slice_s[5];
    slice_c3_s   = slice_s[4];
    ovf_step_s   = slice_c3_s ^ slice_cout_s;
    res_step_s   = result_r;
    res_step_s[{cnt_r, 2'b00} +: 4] = slice_s[3:0];
    res_final_s  = res_step_s;
`ifdef ADDSUB_SAT_EN
    if (ovf_step_s) begin
      res_final_s = sat_value(a_r[W-1]);
    end else begin
      res_final_s = res_step_s;
    end
`endif
    zero_final_s = (res_final_s == {W{1'b0}});
  end

  // Control FSM: state, step counter and the registered handshake/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_RUN;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
          out_valid_r <= 1'b0;
        end
        ST_RUN: begin
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {CW{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture: a, b and mode are sampled only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= {W{1'b0}};
      b_r    <= {W{1'b0}};
      mode_r <= 1'b0;
    end else if (accept_s) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
    end else begin
      a_r    <= a_r;
      b_r    <= b_r;
      mode_r <= mode_r;
    end
  end

  // Datapath: nibble result write-back, carry chain and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r  <= 1'b0;
      result_r <= {W{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept_s) begin
      // Subtract starts with carry-in 1 to complete the two's complement.
      carry_r <= mode;
    end else if (state_r == ST_RUN) begin
      carry_r <= slice_cout_s;
      if (last_s) begin
        result_r <= res_final_s;
        cout_r   <= slice_cout_s;
        ovf_r    <= ovf_step_s;
        zero_r   <= zero_final_s;
      end else begin
        result_r <= res_step_s;
      end
    end else begin
      carry_r  <= carry_r;
      result_r <= result_r;
    end
  end

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Self-checking bench for addsub_serial_ctrl (NIBBLES = 4, W = 16).
// A transaction-level model computes results from plain integer arithmetic.
// It tracks handshake timing as accept / fixed latency / hold-until-taken.
// A per-cycle compare process checks the DUT against that model, and
// directed vectors pin both the DUT and the model to hand-computed values.
module tb_addsub_serial_ctrl;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model state
  bit           m_ready, m_valid, m_busy, m_clean;
  int           m_left;
  logic [W-1:0] p_res, e_res;
  bit           p_c, p_o, p_z, e_c, e_o, e_z;

  addsub_serial_ctrl #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                 output logic [W-1:0] r, output bit c, output bit o, output bit z);
    int ux, uy, sx, sy, ut, st;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - 65536 : ux;
    sy = y[W-1] ? uy - 65536 : uy;
    if (m) begin
      ut = ux - uy;
      st = sx - sy;
      c  = (ux >= uy);
    end else begin
      ut = ux + uy;
      st = sx + sy;
      c  = (ut > 65535);
    end
    r = ut[15:0];
    o = (st > 32767) || (st < -32768);
`ifdef ADDSUB_SAT_EN
    if (o) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    z = (r == 16'h0000);
  endfunction

  // Transaction model: accept, NIB cycles of work, hold until taken.
  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_clean = 1'b1; m_left = 0;
      e_res = 16'h0000; e_c = 1'b0; e_o = 1'b0; e_z = 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        e_res = p_res; e_c = p_c; e_o = p_o; e_z = p_z;
      end
    end else begin
      if (in_valid && m_ready) begin
        golden(a, b, mode, p_res, p_c, p_o, p_z);
        m_left = NIB; m_busy = 1'b1; m_ready = 1'b0; m_clean = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, m_ready);
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_busy);
      if (m_valid || m_clean) begin
        check("result", result, e_res);
        check("cout", cout, e_c);
        check("ovf", ovf, e_o);
        check("zero", zero, e_z);
      end
    end
  end

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One full operation with literal expectations; called at a negedge in IDLE.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                       input logic [W-1:0] lr, input bit lc, input bit lo, input bit lz,
                       input int hold, input bit tie);
    int lat;
    logic [W-1:0] r;
    bit c, o, z;
    golden(x, y, m, r, c, o, z);
    check("model_res", r, lr);
    check("model_cout", c, lc);
    check("model_ovf", o, lo);
    check("model_zero", z, lz);
    in_valid = 1'b1; a = x; b = y; mode = m; out_ready = tie;
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; mode = ~m;
    wait_out_valid(lat);
    check("latency", lat, NIB);
    check("lit_res", result, lr);
    check("lit_cout", cout, lc);
    check("lit_ovf", ovf, lo);
    check("lit_zero", zero, lz);
    if (!tie) begin
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", {cout, ovf, zero}, 3'b000);
    started = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1'b1);

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b1);
`ifdef ADDSUB_SAT_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 2, 1'b0);
`else
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 2, 1'b0);
`endif
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    // Backpressure: hold the result, keep a stale request pending.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid(lat);
    check("bp_latency", lat, NIB);
    in_valid = 1'b1; a = 16'h0100; b = 16'h0001; mode = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_result", result, 16'h3333);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_after_take", busy, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; a = 16'hAAAA; b = 16'h5555;
    check("bp_second_accepted", busy, 1'b1);
    wait_out_valid(lat);
    check("bp2_latency", lat, NIB);
    check("bp2_result", result, 16'h00FF);
    check("bp2_cout", cout, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset two cycles into RUN: operation discarded.
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_valid", out_valid, 1'b0);
    end

    do_op(16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
